pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and bubble injection, generalising the fixed 16-bit stall-gated stage registers between pipeline stages. One instance carries an arbitrary-width payload (instruction, PC+2, control bundle) from stage N to stage N+1. An optional second entry, a skid buffer, registers upstream `in_ready` so back-pressure does not ripple combinationally through the pipe. Sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `WIDTH`, 16: payload width in bits, 1..128.
- `BUBBLE`, 16'h0800: value driven on `out_data` whenever `out_valid`=0 (NOP encoding); width `WIDTH`.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage accepts payload this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  downstream payload valid.
- `out_ready`  in  1  downstream accepts payload this cycle.
- `out_data`  out  WIDTH  payload to next stage.
- `occupancy`  out  2  entries held (0..2).
- `err`  out  1  one-cycle pulse on upstream handshake violation.

## Operation
- push = `in_valid & in_ready & ~flush`; pop = `out_valid & out_ready`.
- Storage: main entry M (drives `out_data`), skid entry S (`PIPE_SKID_EN` only).
- States: EMPTY (occ 0), ONE (occ 1), FULL (occ 2, skid build only).
  - EMPTY: push -> ONE, M<=in_data.
  - ONE: push&pop -> ONE, M<=in_data; push&~pop -> FULL, S<=in_data; pop&~push -> EMPTY.
  - FULL: pop -> ONE, M<=S; push impossible (`in_ready`=0).
- `flush`=1: next state EMPTY regardless of push/pop; any push that cycle discarded; pop still counts downstream (downstream consumed it).
- `out_valid` = (state != EMPTY); `out_data` = M when valid, else `BUBBLE`.
- `occupancy` = state encoding 0/1/2.
- `err`: registered; asserted for exactly one cycle after a cycle t where `in_valid`=1, `in_ready`=0, `flush`=0, and at t+1 either `in_valid`=0 or `in_data` differs from its value at t. Never set by flush cycles. S and M contents are not affected by `err`.

## Timing
- Reset (rst_n=0, async): state EMPTY, `out_valid`=0, `out_data`=`BUBBLE`, `occupancy`=0, `err`=0, M and S cleared to `BUBBLE`; `in_ready`=1 while in reset-released EMPTY.
- Latency: push at edge t -> `out_valid`=1 with that data after edge t (visible cycle t+1).
- Throughput: 1 transfer/cycle sustained with `out_ready`=1.
- Order: strictly FIFO; M always older than S.
- Reset deassertion mid-stream: all entries lost; no partial payload ever appears on `out_data`.
- Simultaneous flush and push in EMPTY: stays EMPTY, `out_data`=`BUBBLE`.

## Configuration
- Macro `PIPE_SKID_EN`.
- Defined: two entries (M+S); `in_ready` = (state != FULL), a pure function of registered state, no combinational path from `out_ready`.
- Undefined: single entry M only; state FULL unreachable, `occupancy` max 1; `in_ready` = `out_ready | ~out_valid` (combinational); push&pop in ONE replaces M same cycle.

## Test plan
- Reset: hold `rst_n`=0 mid-stream with data 16'h1234 held -> immediately `out_valid`=0, `out_data`=16'h0800, `occupancy`=0, `err`=0.
- Streaming: `out_ready`=1, push 16'hA001..16'hA008 back-to-back -> same sequence on `out_data` one cycle later, no gaps, `occupancy` stays 1.
- Back-pressure (skid build): push 16'hB001,16'hB002,16'hB003 with `out_ready`=0 -> `occupancy` 1 then 2, `in_ready`=0 after second push, B003 held upstream; release `out_ready` -> B001,B002,B003 in order.
- Flush: occupancy 2 holding 16'hC001/16'hC002, assert `flush` with `in_valid`=1 data 16'hC003 -> next cycle `out_valid`=0, `out_data`=16'h0800, `occupancy`=0; C003 never emitted.
- Handshake violation: `in_valid`=1 data 16'hD001 while `in_ready`=0, next cycle data 16'hD002 -> `err`=1 for exactly one cycle; dropping `in_valid` instead -> same pulse; same scenario with `flush`=1 -> `err` stays 0.
- No-skid build: `out_ready` toggled 1,0,1 with continuous pushes 16'hE001.. -> `in_ready` follows `out_ready` combinationally, `occupancy` never exceeds 1, no data loss.

Source files
------------

// File: rtl/pipe_stage_if.sv
// Handshake bundle for one pipeline stage register: upstream side, downstream side, flush and status.
// The master modport is the surrounding pipeline; the slave modport is the stage itself.
interface pipe_stage_if #(
    parameter int unsigned WIDTH = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic             err;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, err
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, err
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and bubble injection.
// Define PIPE_SKID_EN for a second (skid) entry that makes in_ready a function of registered state only.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH  = 16,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(16'h0800)
) (
    input logic         clk,
    input logic         rst_n,
    pipe_stage_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] held_q;
    logic             viol_q, viol_d;
    logic             err_q, err_d;
    logic             ready;
    logic             push;
    logic             pop;

`ifdef PIPE_SKID_EN
    logic [WIDTH-1:0] s_q, s_d;
    assign ready = (state_q != FULL);
`else
    assign ready = bus.out_ready | (state_q == EMPTY);
`endif

    assign push = bus.in_valid & ready & ~bus.flush;
    assign pop  = (state_q != EMPTY) & bus.out_ready;

    // M is reloaded with BUBBLE whenever the stage empties, so out_data needs no output mux
    assign bus.in_ready  = ready;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = m_q;
    assign bus.occupancy = 2'(state_q);
    assign bus.err       = err_q;

    // Next-state and entry update
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
`ifdef PIPE_SKID_EN
        s_d     = s_q;
`endif
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    m_d     = bus.in_data;
                end
            end
            ONE: begin
                if (push && pop) begin
                    m_d = bus.in_data;
`ifdef PIPE_SKID_EN
                end else if (push) begin
                    state_d = FULL;
                    s_d     = bus.in_data;
`endif
                end else if (pop) begin
                    state_d = EMPTY;
                    m_d     = BUBBLE;
                end
            end
`ifdef PIPE_SKID_EN
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    m_d     = s_q;
                    s_d     = BUBBLE;
                end
            end
`endif
            default: begin
                state_d = EMPTY;
                m_d     = BUBBLE;
            end
        endcase
        if (bus.flush) begin
            state_d = EMPTY;
            m_d     = BUBBLE;
`ifdef PIPE_SKID_EN
            s_d     = BUBBLE;
`endif
        end
    end

    // A blocked offer must be held unchanged on the following cycle; flush cycles are exempt
    always_comb begin
        viol_d = bus.in_valid & ~ready & ~bus.flush;
        err_d  = viol_q & ~bus.flush & (~bus.in_valid | (bus.in_data != held_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            m_q     <= BUBBLE;
`ifdef PIPE_SKID_EN
            s_q     <= BUBBLE;
`endif
            held_q  <= '0;
            viol_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
`ifdef PIPE_SKID_EN
            s_q     <= s_d;
`endif
            held_q  <= bus.in_data;
            viol_q  <= viol_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; covers both the default and PIPE_SKID_EN builds.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pipe_stage_if #(.WIDTH(16)) bus ();

    pipe_stage_reg #(.WIDTH(16), .BUBBLE(16'h0800)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] a, input logic [15:0] b);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = a;
        step();
        bus.in_data   = b;
`ifdef PIPE_SKID_EN
        step();
`endif
        bus.in_valid  = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        #12;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0800) begin errors++; $display("FAIL rst_data got %h want 0800", bus.out_data); end
        checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL rst_occ got %0d want 0", bus.occupancy); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", bus.err); end
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        bus.in_valid = 1'b1; bus.in_data = 16'h1234;
        step();
        checks++; if (bus.out_data !== 16'h1234) begin errors++; $display("FAIL pre_rst_data got %h want 1234", bus.out_data); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0800) begin errors++; $display("FAIL midrst_data got %h want 0800", bus.out_data); end
        checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL midrst_occ got %0d want 0", bus.occupancy); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", bus.err); end
        bus.in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0800) begin errors++; $display("FAIL postrst_empty got %b/%h want 0/0800", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_streaming();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'hA001 + 16'(i);
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hA001 + 16'(i)) begin errors++; $display("FAIL stream_data[%0d] got %b/%h want 1/%h", i, bus.out_valid, bus.out_data, 16'hA001 + 16'(i)); end
            checks++; if (bus.occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d want 1", i, bus.occupancy); end
        end
        bus.in_valid = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0800 || bus.occupancy !== 2'd0) begin errors++; $display("FAIL stream_end got %b/%h/%0d want 0/0800/0", bus.out_valid, bus.out_data, bus.occupancy); end
        bus.out_ready = 1'b0;
    endtask

`ifdef PIPE_SKID_EN
    task automatic test_back_pressure();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'hB001;
        step();
        checks++; if (bus.occupancy !== 2'd1 || bus.out_data !== 16'hB001) begin errors++; $display("FAIL bp_first got %0d/%h want 1/B001", bus.occupancy, bus.out_data); end
        bus.in_data = 16'hB002;
        step();
        checks++; if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got occ %0d rdy %b want 2/0", bus.occupancy, bus.in_ready); end
        bus.in_data = 16'hB003;
        step();
        checks++; if (bus.occupancy !== 2'd2 || bus.out_data !== 16'hB001) begin errors++; $display("FAIL bp_hold got %0d/%h want 2/B001", bus.occupancy, bus.out_data); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_no_comb_ready got %b want 0", bus.in_ready); end
        step();
        checks++; if (bus.out_data !== 16'hB002 || bus.occupancy !== 2'd1) begin errors++; $display("FAIL bp_second got %h/%0d want B002/1", bus.out_data, bus.occupancy); end
        step();
        checks++; if (bus.out_data !== 16'hB003 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got %b/%h want 1/B003", bus.out_valid, bus.out_data); end
        bus.in_valid = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL bp_end got valid %b err %b want 0/0", bus.out_valid, bus.err); end
        bus.out_ready = 1'b0;
    endtask
`else
    task automatic test_no_skid();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'hE001;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ns_rdy0 got %b want 1", bus.in_ready); end
        step();
        checks++; if (bus.out_data !== 16'hE001 || bus.occupancy !== 2'd1) begin errors++; $display("FAIL ns_first got %h/%0d want E001/1", bus.out_data, bus.occupancy); end
        bus.in_data = 16'hE002; bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ns_rdy_follow0 got %b want 0", bus.in_ready); end
        step();
        checks++; if (bus.out_data !== 16'hE001 || bus.occupancy !== 2'd1) begin errors++; $display("FAIL ns_stall got %h/%0d want E001/1", bus.out_data, bus.occupancy); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ns_rdy_follow1 got %b want 1", bus.in_ready); end
        step();
        checks++; if (bus.out_data !== 16'hE002 || bus.occupancy !== 2'd1) begin errors++; $display("FAIL ns_second got %h/%0d want E002/1", bus.out_data, bus.occupancy); end
        bus.in_data = 16'hE003;
        step();
        checks++; if (bus.out_data !== 16'hE003) begin errors++; $display("FAIL ns_third got %h want E003", bus.out_data); end
        bus.in_valid = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL ns_end got valid %b err %b want 0/0", bus.out_valid, bus.err); end
        bus.out_ready = 1'b0;
    endtask
`endif

    task automatic test_flush();
        logic [1:0] full_occ;
`ifdef PIPE_SKID_EN
        full_occ = 2'd2;
`else
        full_occ = 2'd1;
`endif
        fill(16'hC001, 16'hC002);
        checks++; if (bus.occupancy !== full_occ) begin errors++; $display("FAIL fl_fill got %0d want %0d", bus.occupancy, full_occ); end
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'hC003; bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0800 || bus.occupancy !== 2'd0) begin errors++; $display("FAIL fl_squash got %b/%h/%0d want 0/0800/0", bus.out_valid, bus.out_data, bus.occupancy); end
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL fl_after got valid %b err %b want 0/0", bus.out_valid, bus.err); end
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'hC004;
        step();
        checks++; if (bus.occupancy !== 2'd0 || bus.out_data !== 16'h0800) begin errors++; $display("FAIL fl_empty_push got %0d/%h want 0/0800", bus.occupancy, bus.out_data); end
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic test_violation();
        fill(16'h0011, 16'h0022);
        bus.in_valid = 1'b1; bus.in_data = 16'hD001;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hv_blocked got %b want 0", bus.in_ready); end
        step();
        bus.in_data = 16'hD002;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL hv_early got %b want 0", bus.err); end
        step();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL hv_data_pulse got %b want 1", bus.err); end
        checks++; if (bus.out_data !== 16'h0011) begin errors++; $display("FAIL hv_data_kept got %h want 0011", bus.out_data); end
        step();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL hv_one_cycle got %b want 0", bus.err); end
        bus.in_valid = 1'b0;
        step();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL hv_drop_pulse got %b want 1", bus.err); end
        step();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL hv_drop_end got %b want 0", bus.err); end
        drain();
        fill(16'h0033, 16'h0044);
        bus.in_valid = 1'b1; bus.in_data = 16'hD001; bus.flush = 1'b1;
        step();
        bus.in_data = 16'hD002;
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL hv_flush_a got %b want 0", bus.err); end
        step();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL hv_flush_b got %b want 0", bus.err); end
        drain();
    endtask

    initial begin
        test_reset();
        test_streaming();
`ifdef PIPE_SKID_EN
        test_back_pressure();
`else
        test_no_skid();
`endif
        test_flush();
        test_violation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
